dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 11 +
 rtl/dmem_rr_pick.sv | 13 +
 rtl/dmem_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared defaults and FSM state encoding for the data-memory arbiter.
package dmem_arb_pkg;
   localparam int DMEM_ADDR_W = 10;
   localparam int DMEM_DATA_W = 64;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } arb_state_e;
endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin pick: a sole requester wins, a tie goes to the port not granted last.
module dmem_rr_pick (
   input  logic req0,
   input  logic req1,
   input  logic lastGrant,
   output logic grant,
   output logic valid
);
   always_comb begin
      grant = (req0 & req1) ? ~lastGrant : req1;
      valid = req0 | req1;
   end
endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters onto one data memory; each transaction is IDLE -> ACCESS -> DONE.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = DMEM_ADDR_W,
   parameter int DATA_W = DMEM_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] memAddr,
   output logic [DATA_W-1:0] memWriteData,
   output logic              memWrite,
   output logic              memRead,
   input  logic [DATA_W-1:0] memReadData,
   output logic              busy
);
   arb_state_e        state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              hold_port_q, hold_port_d;
   logic              hold_we_q, hold_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_write_q, mem_write_d;
   logic              mem_read_q, mem_read_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              ack0_q, ack0_d;
   logic              ack1_q, ack1_d;
   logic              busy_q, busy_d;
   logic              pick_grant;
   logic              pick_valid;
   logic              sel_we;

   dmem_rr_pick u_pick (
      .req0      (req0),
      .req1      (req1),
      .lastGrant (last_grant_q),
      .grant     (pick_grant),
      .valid     (pick_valid)
   );

   assign sel_we = pick_grant ? we1 : we0;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      hold_port_d  = hold_port_q;
      hold_we_d    = hold_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_write_d  = mem_write_q;
      mem_read_d   = mem_read_q;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      ack0_d       = ack0_q;
      ack1_d       = ack1_q;
      busy_d       = busy_q;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               // The mem address/data registers double as the holding registers.
               state_d      = ACCESS;
               last_grant_d = pick_grant;
               hold_port_d  = pick_grant;
               hold_we_d    = sel_we;
               mem_addr_d   = pick_grant ? addr1 : addr0;
               mem_wdata_d  = pick_grant ? wdata1 : wdata0;
               mem_write_d  = sel_we;
               mem_read_d   = ~sel_we;
               busy_d       = 1'b1;
            end
         end
         ACCESS: begin
            state_d     = DONE;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
            mem_write_d = 1'b0;
            mem_read_d  = 1'b0;
            if (!hold_we_q) begin
               if (hold_port_q) rdata1_d = memReadData;
               else             rdata0_d = memReadData;
            end
            ack0_d = ~hold_port_q;
            ack1_d = hold_port_q;
         end
         DONE: begin
            state_d = IDLE;
            ack0_d  = 1'b0;
            ack1_d  = 1'b0;
            busy_d  = 1'b0;
         end
         default: begin
            state_d     = IDLE;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
            mem_write_d = 1'b0;
            mem_read_d  = 1'b0;
            ack0_d      = 1'b0;
            ack1_d      = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   // lastGrant resets to 1 so port 0 wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         hold_port_q  <= 1'b0;
         hold_we_q    <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         hold_port_q  <= hold_port_d;
         hold_we_q    <= hold_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_write_q  <= mem_write_d;
         mem_read_q   <= mem_read_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         busy_q       <= busy_d;
      end
   end

   assign ack0         = ack0_q;
   assign ack1         = ack1_q;
   assign rdata0       = rdata0_q;
   assign rdata1       = rdata1_q;
   assign memAddr      = mem_addr_q;
   assign memWriteData = mem_wdata_q;
   assign memWrite     = mem_write_q;
   assign memRead      = mem_read_q;
   assign busy         = busy_q;
endmodule
